// File: rtl/abba_gen.sv
// -----------------------------------------------------------------------------
// abba_gen : symbol-sequence generator for the "abba" Mealy recogniser (m1).
//
// When start is seen while idle, the block emits the word a, b, b, a on x,
// REPS times back to back. Each symbol stays on x for HOLD clock cycles. After
// the last symbol it spends one cycle in DONE, with done high and busy still
// high, and then returns to idle.
//
// Parameters:
//   A_SYM, B_SYM, IDLE_SYM : symbol encodings for a, b and idle
//   HOLD                   : cycles each symbol stays on x (1..255)
//   REPS                   : abba words emitted per start (1..255)
//
// Ports:
//   clock   in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   start   in   transmission request; honoured only while idle
//   x       out  [1:2] registered symbol to the recogniser
//   valid   out  high while x carries a word symbol
//   busy    out  high from the accepted start through the done cycle
//   done    out  one-cycle pulse after the last symbol
//
// Optional feature macro: ABBA_GEN_LOOP_EN
//   When defined, start still high at the end of the final word restarts
//   emission at once, with no DONE cycle. done pulses only when start is low
//   at that boundary.
// -----------------------------------------------------------------------------
module abba_gen #(
  parameter logic [1:0] A_SYM    = 2'b01,
  parameter logic [1:0] B_SYM    = 2'b10,
  parameter logic [1:0] IDLE_SYM = 2'b00,
  parameter int         HOLD     = 1,
  parameter int         REPS     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:2] x,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [7:0] REPS_LAST = 8'(REPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [7:0] hold_cnt;
  logic [7:0] rep_cnt;

  // Map a word position (0..3) to its symbol: a b b a.
  function automatic logic [1:2] sym_of(input logic [1:0] pos);
    return (pos == 2'd0 || pos == 2'd3) ? A_SYM : B_SYM;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      hold_cnt <= 8'd0;
      rep_cnt  <= 8'd0;
      x        <= IDLE_SYM;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_EMIT;
            idx      <= 2'd0;
            hold_cnt <= 8'd0;
            rep_cnt  <= 8'd0;
            x        <= A_SYM;
            valid    <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_EMIT: begin
          if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            hold_cnt <= 8'd0;
            if (idx < 2'd3) begin
              idx <= idx + 2'd1;
              x   <= sym_of(idx + 2'd1);
            end else if (rep_cnt < REPS_LAST) begin
              // Next word follows immediately, no idle symbol in between.
              idx     <= 2'd0;
              rep_cnt <= rep_cnt + 8'd1;
              x       <= A_SYM;
            end
`ifdef ABBA_GEN_LOOP_EN
            else if (start) begin
              // Start still high at the final boundary: restart the full run.
              idx     <= 2'd0;
              rep_cnt <= 8'd0;
              x       <= A_SYM;
            end
`endif
            else begin
              state <= S_DONE;
              x     <= IDLE_SYM;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // start is ignored here; a new request must be seen in idle.
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          x     <= IDLE_SYM;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
